// File: rtl/coin_pkg.sv
// Shared types and constants for the coin payout slice: FSM states,
// denomination values and the coin-select code passed from selector to FSM.
package coin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        WAIT,
        DONE
    } state_t;

    localparam int ONE  = 1;
    localparam int TWO  = 2;
    localparam int FIVE = 5;

    typedef enum logic [1:0] {
        NONE,
        C1,
        C2,
        C5
    } coin_sel_t;

    // Face value of a selected coin; NONE is worth nothing.
    function automatic logic [2:0] coin_value(input coin_sel_t c);
        case (c)
            C1:      return 3'(ONE);
            C2:      return 3'(TWO);
            C5:      return 3'(FIVE);
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin selector: the largest denomination that fits the amount
// still owed and is in stock, or NONE when nothing qualifies.
module coin_select
    import coin_pkg::*;
#(
    parameter int AMT_W = 4,
    parameter int INV_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [INV_W-1:0] inv_ones,
    input  logic [INV_W-1:0] inv_twos,
    input  logic [INV_W-1:0] inv_fives,
    output coin_sel_t        sel
);

    always_comb begin
        sel = NONE;
        if (remaining >= AMT_W'(FIVE) && inv_fives != '0) begin
            sel = C5;
        end else if (remaining >= AMT_W'(TWO) && inv_twos != '0) begin
            sel = C2;
        end else if (remaining >= AMT_W'(ONE) && inv_ones != '0) begin
            sel = C1;
        end
    end

endmodule

// File: rtl/coin_payout.sv
// Change-payout controller: pays a requested amount one coin at a time to a
// hopper, waiting for its acknowledge, and keeps per-denomination inventory.
module coin_payout
    import coin_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int INV_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             resetn,
    // req_valid/req_ready: a request transfers on a rising edge where both are
    // high; req_ready depends only on state (high in IDLE), never on req_valid.
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load,
    input  logic [INV_W-1:0] load_ones,
    input  logic [INV_W-1:0] load_twos,
    input  logic [INV_W-1:0] load_fives,
    input  logic             hop_done,
    output logic             oneout,
    output logic             twoout,
    output logic             fiveout,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_ones,
    output logic [INV_W-1:0] inv_twos,
    output logic [INV_W-1:0] inv_fives,
    output state_t           state_dbg
);

    // The wait counter only needs to reach TIMEOUT-1 before leaving WAIT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q;
    logic [INV_W-1:0] inv1_q, inv2_q, inv5_q;
    coin_sel_t        sel, sel_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             wait_expired;

    coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_select (
        .remaining (remaining_q),
        .inv_ones  (inv1_q),
        .inv_twos  (inv2_q),
        .inv_fives (inv5_q),
        .sel       (sel)
    );

    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SELECT;
            // NONE covers both a fully paid amount and an empty hopper.
            SELECT:  state_d = (sel == NONE) ? DONE : EJECT;
            EJECT:   state_d = WAIT;
            WAIT: begin
                if (hop_done) begin
                    state_d = SELECT;
                end else if (wait_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            remaining_q <= '0;
            inv1_q      <= '0;
            inv2_q      <= '0;
            inv5_q      <= '0;
            sel_q       <= NONE;
            wait_cnt    <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        inv1_q <= load_ones;
                        inv2_q <= load_twos;
                        inv5_q <= load_fives;
                    end
                    if (req_valid) begin
                        remaining_q <= req_amount;
                    end
                end
                SELECT: begin
                    sel_q <= sel;
                end
                EJECT: begin
                    case (sel_q)
                        C1:      inv1_q <= inv1_q - INV_W'(1);
                        C2:      inv2_q <= inv2_q - INV_W'(1);
                        C5:      inv5_q <= inv5_q - INV_W'(1);
                        default: ;
                    endcase
                    remaining_q <= remaining_q - AMT_W'(coin_value(sel_q));
                    wait_cnt    <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // The ejected coin stays deducted even when the hopper times out.
                    if (!hop_done && wait_expired) begin
                        fault_q <= 1'b1;
                    end
                end
                DONE: begin
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign short     = done && (remaining_q != '0) && !fault_q;
    assign fault     = done && fault_q;
    assign oneout    = (state_q == EJECT) && (sel_q == C1);
    assign twoout    = (state_q == EJECT) && (sel_q == C2);
    assign fiveout   = (state_q == EJECT) && (sel_q == C5);
    assign remaining = remaining_q;
    assign inv_ones  = inv1_q;
    assign inv_twos  = inv2_q;
    assign inv_fives = inv5_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_coin_payout.sv
// Bench for coin_payout: acts as vending controller and hopper, and checks
// each payout against a greedy change model kept in plain arithmetic.
module tb_coin_payout;

    localparam int TIMEOUT = 8;

    logic clk, resetn, req_valid, load, hop_done;
    logic [3:0] req_amount, load_ones, load_twos, load_fives;
    logic req_ready, oneout, twoout, fiveout, busy, done, short, fault;
    logic [3:0] remaining, inv_ones, inv_twos, inv_fives;
    coin_pkg::state_t state_dbg;

    int tests_run;
    int tests_failed;

    // model inventory and expectations
    int m_inv1, m_inv2, m_inv5, exp_rem;
    logic [2:0] exp_q[$];
    // observations of one payout
    logic [2:0] obs_q[$];
    bit obs_done, obs_short, obs_fault, obs_multi;
    int obs_first, obs_done_cyc, obs_rem;

    coin_payout #(.AMT_W(4), .INV_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .load(load), .load_ones(load_ones), .load_twos(load_twos),
        .load_fives(load_fives), .hop_done(hop_done), .oneout(oneout), .twoout(twoout),
        .fiveout(fiveout), .busy(busy), .done(done), .short(short), .fault(fault),
        .remaining(remaining), .inv_ones(inv_ones), .inv_twos(inv_twos),
        .inv_fives(inv_fives), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pay amt greedily from the model inventory, at most max_coins coins.
    task automatic model_payout(input int amt, input int max_coins);
        int r;
        r = amt;
        exp_q.delete();
        while (exp_q.size() < max_coins) begin
            if (r >= 5 && m_inv5 > 0) begin exp_q.push_back(3'd5); r -= 5; m_inv5--; end
            else if (r >= 2 && m_inv2 > 0) begin exp_q.push_back(3'd2); r -= 2; m_inv2--; end
            else if (r >= 1 && m_inv1 > 0) begin exp_q.push_back(3'd1); r -= 1; m_inv1--; end
            else break;
        end
        exp_rem = r;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_inv(input int l1, input int l2, input int l5);
        @(negedge clk);
        load = 1'b1; load_ones = 4'(l1); load_twos = 4'(l2); load_fives = 4'(l5);
        @(negedge clk);
        load = 1'b0;
        m_inv1 = l1; m_inv2 = l2; m_inv5 = l5;
    endtask

    // Issue one request and play hopper. cyc 0 is the cycle after the accept edge.
    task automatic do_payout(input int amt, input int lat, input bit hang,
                             input bit ld_req, input bit ld_busy,
                             input int l1, input int l2, input int l5);
        int cd, n;
        bit armed;
        obs_q.delete();
        obs_done = 0; obs_short = 0; obs_fault = 0; obs_multi = 0;
        obs_first = -1; obs_done_cyc = -1; obs_rem = -1;
        armed = 0; cd = 0;
        @(negedge clk);
        req_valid = 1'b1; req_amount = 4'(amt);
        if (ld_req) begin
            load = 1'b1; load_ones = 4'(l1); load_twos = 4'(l2); load_fives = 4'(l5);
        end
        @(negedge clk);
        req_valid = 1'b0; load = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            n = int'(oneout) + int'(twoout) + int'(fiveout);
            if (n > 1) obs_multi = 1;
            hop_done = 1'b0;
            if (armed) begin
                cd--;
                if (cd == 0) begin hop_done = 1'b1; armed = 0; end
            end
            if (n >= 1) begin
                obs_q.push_back(fiveout ? 3'd5 : (twoout ? 3'd2 : 3'd1));
                if (obs_first < 0) obs_first = cyc;
                if (!hang) begin armed = 1; cd = lat; end
            end
            if (ld_busy && cyc == 1) begin
                load = 1'b1; load_ones = 4'(l1); load_twos = 4'(l2); load_fives = 4'(l5);
            end else begin
                load = 1'b0;
            end
            if (done) begin
                obs_done = 1; obs_done_cyc = cyc;
                obs_short = short; obs_fault = fault; obs_rem = int'(remaining);
                break;
            end
            @(negedge clk);
        end
        hop_done = 1'b0; load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, busy, done, short, fault, oneout, twoout, fiveout} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 10000000",
                     {req_ready, busy, done, short, fault, oneout, twoout, fiveout});
        end
        tests_run++;
        if ({remaining, inv_ones, inv_twos, inv_fives} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h want 0000", {remaining, inv_ones, inv_twos, inv_fives});
        end
        resetn = 1'b1;
        m_inv1 = 0; m_inv2 = 0; m_inv5 = 0;
        // hopper acknowledge while idle must be ignored
        hop_done = 1'b1;
        repeat (2) @(negedge clk);
        hop_done = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_hop_done: busy=%b req_ready=%b want 0/1", busy, req_ready);
        end
    endtask

    task automatic test_basic();
        load_inv(3, 3, 3);
        model_payout(8, 99);
        do_payout(8, 1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (!obs_done || obs_q.size() != 3 || obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL basic_count: done=%0d coins=%0d want done=1 coins=%0d", obs_done, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_coin%0d: got %0d want %0d", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if ({obs_short, obs_fault} !== 2'b00 || obs_rem != 0) begin
            tests_failed++;
            $display("FAIL basic_flags: short=%0d fault=%0d rem=%0d want 0/0/0", obs_short, obs_fault, obs_rem);
        end
        tests_run++;
        if (int'(inv_ones) != 2 || int'(inv_twos) != 2 || int'(inv_fives) != 2) begin
            tests_failed++;
            $display("FAIL basic_inv: got %0d/%0d/%0d want 2/2/2", inv_ones, inv_twos, inv_fives);
        end
        tests_run++;
        if (obs_first != 1 || obs_done_cyc != 3 * 3 + 1) begin
            tests_failed++;
            $display("FAIL basic_timing: first=%0d done=%0d want 1/10", obs_first, obs_done_cyc);
        end
    endtask

    task automatic test_zero();
        model_payout(0, 99);
        do_payout(0, 1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (!obs_done || obs_q.size() != 0 || obs_done_cyc != 1 || obs_short !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_req: done=%0d coins=%0d done_cyc=%0d short=%0d want 1/0/1/0",
                     obs_done, obs_q.size(), obs_done_cyc, obs_short);
        end
    endtask

    task automatic test_short();
        load_inv(1, 1, 0);
        model_payout(5, 99);
        do_payout(5, 2, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs_q.size() != 2 || obs_q[0] !== 3'd2 || obs_q[1] !== 3'd1) begin
            tests_failed++;
            $display("FAIL short_coins: n=%0d want 2 (two then one)", obs_q.size());
        end
        tests_run++;
        if (!obs_done || obs_short !== 1'b1 || obs_fault !== 1'b0 || obs_rem != exp_rem || exp_rem != 2) begin
            tests_failed++;
            $display("FAIL short_flags: done=%0d short=%0d fault=%0d rem=%0d want 1/1/0/2",
                     obs_done, obs_short, obs_fault, obs_rem);
        end
        tests_run++;
        if ({inv_ones, inv_twos, inv_fives} !== 12'h000) begin
            tests_failed++;
            $display("FAIL short_inv: got %0d/%0d/%0d want 0/0/0", inv_ones, inv_twos, inv_fives);
        end
        // greedy example: 6 from fives=1 twos=3 ones=0 leaves 1 owed
        load_inv(0, 3, 1);
        model_payout(6, 99);
        do_payout(6, 1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs_q.size() != 1 || obs_q[0] !== 3'd5 || obs_short !== 1'b1 || obs_rem != 1) begin
            tests_failed++;
            $display("FAIL greedy_six: coins=%0d short=%0d rem=%0d want 1/1/1", obs_q.size(), obs_short, obs_rem);
        end
    endtask

    task automatic test_timeout();
        load_inv(2, 2, 2);
        model_payout(7, 1);
        do_payout(7, 1, 1, 0, 0, 0, 0, 0);
        tests_run++;
        if (!obs_done || obs_fault !== 1'b1 || obs_short !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_flags: done=%0d fault=%0d short=%0d want 1/1/0", obs_done, obs_fault, obs_short);
        end
        tests_run++;
        if (obs_first < 0 || obs_done_cyc - obs_first != TIMEOUT + 1) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d want %0d", obs_done_cyc - obs_first, TIMEOUT + 1);
        end
        tests_run++;
        if (obs_q.size() != 1 || obs_rem != exp_rem || int'(inv_fives) != m_inv5 || int'(inv_twos) != m_inv2) begin
            tests_failed++;
            $display("FAIL timeout_deduct: coins=%0d rem=%0d fives=%0d want 1/%0d/%0d",
                     obs_q.size(), obs_rem, inv_fives, exp_rem, m_inv5);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_inv(3, 3, 3);
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_amount = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (fiveout) seen = 1;
            @(negedge clk);
        end
        // now in the first WAIT cycle with no acknowledge
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_inv1 = 0; m_inv2 = 0; m_inv5 = 0;
        tests_run++;
        if (!seen || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            {inv_ones, inv_twos, inv_fives, remaining} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid: seen=%0d ready=%b busy=%b done=%b inv=%0d/%0d/%0d want 1/1/0/0/0",
                     seen, req_ready, busy, done, inv_ones, inv_twos, inv_fives);
        end
        seen = 0;
        repeat (TIMEOUT + 4) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got done/busy activity want none");
        end
    endtask

    task automatic test_load_rules();
        load_inv(2, 2, 2);
        model_payout(3, 99);
        do_payout(3, 1, 0, 0, 1, 9, 9, 9);
        tests_run++;
        if (int'(inv_ones) != m_inv1 || int'(inv_twos) != m_inv2 || int'(inv_fives) != m_inv5) begin
            tests_failed++;
            $display("FAIL load_busy: got %0d/%0d/%0d want %0d/%0d/%0d",
                     inv_ones, inv_twos, inv_fives, m_inv1, m_inv2, m_inv5);
        end
        // load together with the request: payout sees the new counts
        m_inv1 = 0; m_inv2 = 0; m_inv5 = 1;
        model_payout(9, 99);
        do_payout(9, 1, 0, 1, 0, 0, 0, 1);
        tests_run++;
        if (obs_q.size() != exp_q.size() || obs_rem != exp_rem || obs_short !== 1'b1 ||
            int'(inv_fives) != m_inv5) begin
            tests_failed++;
            $display("FAIL load_with_req: coins=%0d rem=%0d fives=%0d want %0d/%0d/%0d",
                     obs_q.size(), obs_rem, inv_fives, exp_q.size(), exp_rem, m_inv5);
        end
    endtask

    task automatic test_random();
        int amt, lat, l1, l2, l5;
        bit ld_req, ld_busy, ok;
        for (int it = 0; it < 30; it++) begin
            amt = $urandom_range(0, 15);
            lat = $urandom_range(1, TIMEOUT);
            l1 = $urandom_range(0, 4); l2 = $urandom_range(0, 4); l5 = $urandom_range(0, 3);
            ld_req = ($urandom_range(0, 2) == 0);
            ld_busy = !ld_req && ($urandom_range(0, 3) == 0);
            if (!ld_req && !ld_busy && $urandom_range(0, 1) == 0) load_inv(l1, l2, l5);
            if (ld_req) begin m_inv1 = l1; m_inv2 = l2; m_inv5 = l5; end
            model_payout(amt, 99);
            do_payout(amt, lat, 0, ld_req, ld_busy, l1, l2, l5);
            ok = obs_done && !obs_multi && obs_q.size() == exp_q.size() && obs_rem == exp_rem &&
                 obs_short == (exp_rem != 0) && !obs_fault &&
                 obs_done_cyc == exp_q.size() * (2 + lat) + 1;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) ok = 0;
            if (int'(inv_ones) != m_inv1 || int'(inv_twos) != m_inv2 || int'(inv_fives) != m_inv5) ok = 0;
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL random%0d amt=%0d lat=%0d: coins=%0d rem=%0d short=%0d fault=%0d done_cyc=%0d inv=%0d/%0d/%0d want coins=%0d rem=%0d done_cyc=%0d inv=%0d/%0d/%0d",
                         it, amt, lat, obs_q.size(), obs_rem, obs_short, obs_fault, obs_done_cyc,
                         inv_ones, inv_twos, inv_fives, exp_q.size(), exp_rem,
                         exp_q.size() * (2 + lat) + 1, m_inv1, m_inv2, m_inv5);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run = 0; tests_failed = 0;
        resetn = 1'b0; req_valid = 1'b0; req_amount = '0; load = 1'b0;
        load_ones = '0; load_twos = '0; load_fives = '0; hop_done = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_short();
        test_timeout();
        test_reset_mid();
        test_load_rules();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
